// File: rtl/hvgen_prm_if.sv
// hvgen_prm_if -- bundles the timing generator's enable/flip inputs and all of
// its video timing outputs.
//   slave  : the generator side (hvgen_prm) - reads iCE/iFLIP, drives o*.
//   master : the consumer side - drives iCE/iFLIP, reads o*.
// W sets the width of the position outputs and must match the generator's W.
interface hvgen_prm_if #(parameter int W = 9);
  logic         iCE;
  logic         iFLIP;
  logic [W-1:0] oHPOS;
  logic [W-1:0] oVPOS;
  logic         oHBLK;
  logic         oVBLK;
  logic         oHSYN;
  logic         oVSYN;
  logic         oBLKN;
  logic         oLINE;
  logic         oFRAME;
  logic [7:0]   oFCNT;

  modport master (
    output iCE, iFLIP,
    input  oHPOS, oVPOS, oHBLK, oVBLK, oHSYN, oVSYN, oBLKN, oLINE, oFRAME, oFCNT
  );
  modport slave (
    input  iCE, iFLIP,
    output oHPOS, oVPOS, oHBLK, oVBLK, oHSYN, oVSYN, oBLKN, oLINE, oFRAME, oFCNT
  );
endinterface

// File: rtl/hvgen_prm.sv
// hvgen_prm -- parameterised horizontal/vertical video timing generator.
//   iPCLK : pixel clock, all state on rising edge
//   iRST  : asynchronous active-high reset
//   bus   : hvgen_prm_if.slave
//           iCE   pixel enable (state advances only when 1)
//           iFLIP screen flip request (sampled at frame boundary)
//           oHPOS/oVPOS positions, oHBLK/oVBLK blanks (high),
//           oHSYN/oVSYN syncs (low), oBLKN display enable,
//           oLINE/oFRAME one-enabled-cycle strobes, oFCNT frame count.
// Optional feature: define HVGEN_FLIP_EN to build the screen-flip logic.
// Every output comes straight from a register.
module hvgen_prm #(
  parameter int W        = 9,
  parameter int HBLK_ON  = 288,
  parameter int HSYN_ON  = 311,
  parameter int HSYN_OFF = 342,
  parameter int HJMP     = 471,
  parameter int HMAX     = 511,
  parameter int VBLK_ON  = 223,
  parameter int VSYN_ON  = 226,
  parameter int VSYN_OFF = 233,
  parameter int VJMP     = 483,
  parameter int VMAX     = 511
) (
  input logic         iPCLK,
  input logic         iRST,
  hvgen_prm_if.slave  bus
);

  if (!(HBLK_ON < HSYN_ON && HSYN_ON < HSYN_OFF && HSYN_OFF < HJMP &&
        HJMP <= HMAX && HMAX < (1 << W))) begin : g_bad_h
    $error("hvgen_prm: illegal horizontal parameters");
  end
  if (!(VBLK_ON < VSYN_ON && VSYN_ON < VSYN_OFF && VSYN_OFF < VJMP &&
        VJMP <= VMAX && VMAX < (1 << W))) begin : g_bad_v
    $error("hvgen_prm: illegal vertical parameters");
  end

  localparam logic [W-1:0] HBLK_ON_C  = HBLK_ON[W-1:0];
  localparam logic [W-1:0] HSYN_ON_C  = HSYN_ON[W-1:0];
  localparam logic [W-1:0] HSYN_OFF_C = HSYN_OFF[W-1:0];
  localparam logic [W-1:0] HJMP_C     = HJMP[W-1:0];
  localparam logic [W-1:0] HMAX_C     = HMAX[W-1:0];
  localparam logic [W-1:0] VBLK_ON_C  = VBLK_ON[W-1:0];
  localparam logic [W-1:0] VSYN_ON_C  = VSYN_ON[W-1:0];
  localparam logic [W-1:0] VSYN_OFF_C = VSYN_OFF[W-1:0];
  localparam logic [W-1:0] VJMP_C     = VJMP[W-1:0];
  localparam logic [W-1:0] VMAX_C     = VMAX[W-1:0];

  logic [W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic         hblk_q, hblk_d, vblk_q, vblk_d;
  logic         hsyn_q, hsyn_d, vsyn_q, vsyn_d;
  logic         blkn_q, blkn_d, line_q, line_d, frame_q, frame_d;
  logic [7:0]   fcnt_q, fcnt_d;
  logic         h_end;

  assign h_end = (hcnt_q == HMAX_C);

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hblk_d  = hblk_q;
    vblk_d  = vblk_q;
    hsyn_d  = hsyn_q;
    vsyn_d  = vsyn_q;
    fcnt_d  = fcnt_q;
    blkn_d  = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (bus.iCE) begin
      // display enable lags the blanks by one enabled cycle
      blkn_d  = ~(hblk_q | vblk_q);
      line_d  = h_end;
      frame_d = h_end && (vcnt_q == VBLK_ON_C);
      if (frame_d) fcnt_d = fcnt_q + 8'd1;

      if (h_end) begin
        hcnt_d = '0;
        hblk_d = 1'b0;
      end else if (hcnt_q == HSYN_OFF_C) begin
        hsyn_d = 1'b1;
        hcnt_d = HJMP_C;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HBLK_ON_C) hblk_d = 1'b1;
        if (hcnt_q == HSYN_ON_C) hsyn_d = 1'b0;
      end

      // vertical logic steps once per line, on the last pixel
      if (h_end) begin
        if (vcnt_q == VMAX_C) begin
          vcnt_d = '0;
          vblk_d = 1'b0;
        end else if (vcnt_q == VSYN_OFF_C) begin
          vsyn_d = 1'b1;
          vcnt_d = VJMP_C;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q == VBLK_ON_C) vblk_d = 1'b1;
          if (vcnt_q == VSYN_ON_C) vsyn_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iPCLK or posedge iRST) begin
    if (iRST) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= 1'b1;
      vsyn_q  <= 1'b1;
      blkn_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      hsyn_q  <= hsyn_d;
      vsyn_q  <= vsyn_d;
      blkn_q  <= blkn_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HVGEN_FLIP_EN
  logic         flip_q, flip_d;
  logic [W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;

  // Flip is only taken at the frame boundary so a frame is never torn.
  // Positions are computed from next-state counters so they stay aligned.
  always_comb begin
    flip_d = flip_q;
    if (bus.iCE && h_end && (vcnt_q == VMAX_C)) flip_d = bus.iFLIP;
    hpos_d = (flip_d && (hcnt_d < HBLK_ON_C)) ? HSYN_OFF_C - hcnt_d : hcnt_d;
    vpos_d = (flip_d && (vcnt_d < VBLK_ON_C)) ? VSYN_OFF_C - vcnt_d : vcnt_d;
  end

  always_ff @(posedge iPCLK or posedge iRST) begin
    if (iRST) begin
      flip_q <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      flip_q <= flip_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  assign bus.oHPOS = hpos_q;
  assign bus.oVPOS = vpos_q;
`else
  logic unused_flip;
  assign unused_flip = bus.iFLIP;
  assign bus.oHPOS   = hcnt_q;
  assign bus.oVPOS   = vcnt_q;
`endif

  assign bus.oHBLK  = hblk_q;
  assign bus.oVBLK  = vblk_q;
  assign bus.oHSYN  = hsyn_q;
  assign bus.oVSYN  = vsyn_q;
  assign bus.oBLKN  = blkn_q;
  assign bus.oLINE  = line_q;
  assign bus.oFRAME = frame_q;
  assign bus.oFCNT  = fcnt_q;

endmodule
